// File: rtl/seg7_scan_driver.sv
// Binary-to-BCD converter feeding a 4-digit multiplexed 7-segment scanner.
// The digit scan is paced by an externally generated slow_clk, sampled as async data.
module seg7_scan_driver #(
    parameter int WIDTH       = 16,
    parameter bit LZB         = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             slow_clk,
    input  logic [WIDTH-1:0] value,
    input  logic             load,
    input  logic             blank,
    output logic             busy,
    output logic             ovf,
    output logic [3:0]       an,
    output logic [6:0]       seg,
    output logic             dp
);

    localparam int NDIG_RAW = (WIDTH * 3) / 10 + 1;
    localparam int NDIG     = (NDIG_RAW < 4) ? 4 : NDIG_RAW;
    localparam int BCD_W    = 4 * NDIG;
    localparam int IW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [3:0] CODE_DASH = 4'hA;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    // Active-high {g..a} pattern; any code outside 0-9 and DASH renders dark.
    function automatic logic [6:0] pattern(input logic [3:0] code);
        case (code)
            4'd0:      pattern = 7'h3F;
            4'd1:      pattern = 7'h06;
            4'd2:      pattern = 7'h5B;
            4'd3:      pattern = 7'h4F;
            4'd4:      pattern = 7'h66;
            4'd5:      pattern = 7'h6D;
            4'd6:      pattern = 7'h7D;
            4'd7:      pattern = 7'h07;
            4'd8:      pattern = 7'h7F;
            4'd9:      pattern = 7'h6F;
            CODE_DASH: pattern = 7'h40;
            default:   pattern = 7'h00;
        endcase
    endfunction

    // ---------------- slow_clk synchronizer and rising-edge detect
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic                   scan_tick;

    assign scan_tick = sync_q[SYNC_STAGES-1] & ~edge_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], slow_clk};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // ---------------- double-dabble converter
    state_t           state_q;
    logic [BCD_W-1:0] bcd_q;
    logic [BCD_W-1:0] bcd_adj;
    logic [WIDTH-1:0] bin_q;
    logic [IW-1:0]    iter_q;
    logic [3:0]       dig_q [4];

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        bcd_adj = bcd_q;
        for (int n = 0; n < NDIG; n++) begin
            if (bcd_q[4*n +: 4] >= 4'd5)
                bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
        end
    end

    // NOTE: the digit registers are only four nibbles, so they take the async reset like any other state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
            ovf     <= 1'b0;
            bcd_q   <= '0;
            bin_q   <= '0;
            iter_q  <= '0;
            for (int k = 0; k < 4; k++) dig_q[k] <= 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load) begin
                        bin_q   <= value;
                        bcd_q   <= '0;
                        iter_q  <= '0;
                        busy    <= 1'b1;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    bcd_q  <= {bcd_adj[BCD_W-2:0], bin_q[WIDTH-1]};
                    bin_q  <= {bin_q[WIDTH-2:0], 1'b0};
                    iter_q <= iter_q + 1'b1;
                    if (iter_q == IW'(WIDTH - 1))
                        state_q <= S_DONE;
                end
                S_DONE: begin
                    // Anything above the fourth BCD digit means the value exceeds 9999.
                    if ((bcd_q >> 16) != '0) begin
                        ovf <= 1'b1;
                        for (int k = 0; k < 4; k++) dig_q[k] <= CODE_DASH;
                    end else begin
                        ovf <= 1'b0;
                        for (int k = 0; k < 4; k++) dig_q[k] <= bcd_q[4*k +: 4];
                    end
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // ---------------- scan and segment drive
    logic [1:0] idx_q;
    logic [3:0] lz;
    logic       lz_blank;

    always_comb begin
        lz    = 4'b0000;
        lz[3] = (dig_q[3] == 4'd0);
        lz[2] = lz[3] && (dig_q[2] == 4'd0);
        lz[1] = lz[2] && (dig_q[1] == 4'd0);
        lz_blank = LZB && !ovf && lz[idx_q];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q <= 2'd0;
            an    <= 4'b1111;
            seg   <= 7'h7F;
        end else begin
            if (scan_tick)
                idx_q <= idx_q + 2'd1;
            an  <= blank ? 4'b1111 : ~(4'b0001 << idx_q);
            seg <= lz_blank ? 7'h7F : ~pattern(dig_q[idx_q]);
        end
    end

    assign dp = 1'b1;

endmodule
